// File: rtl/abr_prim_pkg.sv
// Shared types for the abr_prim handshake register slices.
package abr_prim_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } abr_subreg_hs_state_e;

endpackage : abr_prim_pkg

// File: rtl/abr_prim_subreg_ext_hs_if.sv
// Request/acknowledge channel between a register slice (master) and the external HW register owner (slave).
interface abr_prim_subreg_ext_hs_if #(
    parameter int DW = 32
);
    logic          req_o;
    logic          req_we_o;
    logic [DW-1:0] req_wd_o;
    logic          ack_i;
    logic [DW-1:0] rdata_i;

    modport master (
        output req_o, req_we_o, req_wd_o,
        input  ack_i, rdata_i
    );

    modport slave (
        input  req_o, req_we_o, req_wd_o,
        output ack_i, rdata_i
    );

endinterface : abr_prim_subreg_ext_hs_if

// File: rtl/abr_prim_subreg_ext_tmo.sv
// Saturating timeout counter: cleared by i_clr, counts while i_en, flags the TMO_CYC-th enabled cycle.
module abr_prim_subreg_ext_tmo #(
    parameter int               TMO_W   = 8,
    parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(200)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    logic [TMO_W-1:0] r_cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TMO_MAX)) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == TMO_LAST);

endmodule : abr_prim_subreg_ext_tmo

// File: rtl/abr_prim_subreg_ext_hs.sv
// External register slice: forwards SW re/we to a HW owner over a registered req/ack handshake,
// with captured read data, timeout abort and sticky error flags.
module abr_prim_subreg_ext_hs
    import abr_prim_pkg::*;
#(
    parameter int               DW        = 32,
    parameter int               TMO_W     = 8,
    parameter logic [TMO_W-1:0] TMO_CYC   = TMO_W'(200),
    parameter logic [DW-1:0]    RESVAL    = '0,
    parameter logic [DW-1:0]    ERR_RDATA = '1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               re,
    input  logic                               we,
    input  logic [DW-1:0]                      wd,
    input  logic                               err_clr,
    abr_prim_subreg_ext_hs_if.master           hs,
    output logic [DW-1:0]                      qs,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_tmo_o,
    output logic                               err_ovf_o
);

    abr_subreg_hs_state_e r_state, w_state_nxt;
    logic                 r_req_we, w_req_we_nxt;
    logic [DW-1:0]        r_req_wd, w_req_wd_nxt;
    logic [DW-1:0]        r_qs, w_qs_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err_tmo, r_err_ovf;
    logic                 w_tmo_set, w_ovf_set;
    logic                 w_expire;

    abr_prim_subreg_ext_tmo #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_clr    (r_state == IDLE),
        .i_en     (r_state == REQ),
        .o_expire (w_expire)
    );

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt  = r_state;
        w_req_we_nxt = r_req_we;
        w_req_wd_nxt = r_req_wd;
        w_qs_nxt     = r_qs;
        w_done_nxt   = 1'b0;
        w_tmo_set    = 1'b0;
        w_ovf_set    = 1'b0;

        case (r_state)
            IDLE: begin
                if (we) begin
                    w_state_nxt  = REQ;
                    w_req_we_nxt = 1'b1;
                    w_req_wd_nxt = wd;
                    w_ovf_set    = re;
                end else if (re) begin
                    w_state_nxt  = REQ;
                    w_req_we_nxt = 1'b0;
                end
            end
            REQ: begin
                w_ovf_set = re | we;
                // Ack takes priority over a timeout landing in the same cycle.
                if (hs.ack_i) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    if (!r_req_we) w_qs_nxt = hs.rdata_i;
                end else if (w_expire) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_tmo_set   = 1'b1;
                    if (!r_req_we) w_qs_nxt = ERR_RDATA;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_req_we  <= 1'b0;
            r_req_wd  <= '0;
            r_qs      <= RESVAL;
            r_done    <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_we  <= w_req_we_nxt;
            r_req_wd  <= w_req_wd_nxt;
            r_qs      <= w_qs_nxt;
            r_done    <= w_done_nxt;
            // A set event in the same cycle as err_clr keeps the flag high.
            r_err_tmo <= w_tmo_set | (r_err_tmo & ~err_clr);
            r_err_ovf <= w_ovf_set | (r_err_ovf & ~err_clr);
        end
    end

    assign hs.req_o    = (r_state == REQ);
    assign hs.req_we_o = r_req_we;
    assign hs.req_wd_o = r_req_wd;
    assign qs          = r_qs;
    assign busy_o      = (r_state == REQ);
    assign done_o      = r_done;
    assign err_tmo_o   = r_err_tmo;
    assign err_ovf_o   = r_err_ovf;

endmodule : abr_prim_subreg_ext_hs

// File: tb/tb_abr_prim_subreg_ext_hs.sv
// Directed bench for abr_prim_subreg_ext_hs with TMO_CYC=4 and a non-zero RESVAL.
module tb_abr_prim_subreg_ext_hs;

    localparam int          DW     = 32;
    localparam logic [31:0] RESVAL = 32'h0000_00C3;
    localparam logic [31:0] ERRV   = 32'hFFFF_FFFF;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          re, we, err_clr;
    logic [DW-1:0] wd;
    logic [DW-1:0] qs;
    logic          busy_o, done_o, err_tmo_o, err_ovf_o;

    int n_cmp = 0;
    int n_mis = 0;

    abr_prim_subreg_ext_hs_if #(.DW(DW)) hs_if ();

    abr_prim_subreg_ext_hs #(
        .DW        (DW),
        .TMO_W     (8),
        .TMO_CYC   (8'd4),
        .RESVAL    (RESVAL),
        .ERR_RDATA (ERRV)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .re        (re),
        .we        (we),
        .wd        (wd),
        .err_clr   (err_clr),
        .hs        (hs_if.master),
        .qs        (qs),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_tmo_o (err_tmo_o),
        .err_ovf_o (err_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; re = 1'b0; we = 1'b0; err_clr = 1'b0; wd = '0;
        hs_if.ack_i = 1'b0; hs_if.rdata_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_req", hs_if.req_o, 0);
        check("rst_req_we", hs_if.req_we_o, 0);
        check("rst_req_wd", hs_if.req_wd_o, 0);
        check("rst_qs", qs, RESVAL);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err_tmo", err_tmo_o, 0);
        check("rst_err_ovf", err_ovf_o, 0);

        // Write, ack in the 3rd REQ cycle
        we = 1'b1; wd = 32'hA5A5_0001;
        tick();
        we = 1'b0;
        check("wr_req_c1", hs_if.req_o, 1);
        check("wr_busy_c1", busy_o, 1);
        check("wr_req_we", hs_if.req_we_o, 1);
        check("wr_req_wd", hs_if.req_wd_o, 32'hA5A5_0001);
        tick();
        check("wr_req_c2", hs_if.req_o, 1);
        check("wr_done_c2", done_o, 0);
        tick();
        check("wr_req_c3", hs_if.req_o, 1);
        hs_if.ack_i = 1'b1;
        tick();
        hs_if.ack_i = 1'b0;
        check("wr_req_end", hs_if.req_o, 0);
        check("wr_done", done_o, 1);
        check("wr_qs", qs, RESVAL);
        check("wr_err_tmo", err_tmo_o, 0);
        check("wr_err_ovf", err_ovf_o, 0);
        tick();
        check("wr_done_once", done_o, 0);

        // Read, immediate ack
        re = 1'b1; hs_if.rdata_i = 32'h1234_5678;
        tick();
        re = 1'b0;
        check("rd_req_c1", hs_if.req_o, 1);
        check("rd_req_we", hs_if.req_we_o, 0);
        hs_if.ack_i = 1'b1;
        tick();
        hs_if.ack_i = 1'b0;
        check("rd_req_end", hs_if.req_o, 0);
        check("rd_done", done_o, 1);
        check("rd_qs", qs, 32'h1234_5678);
        tick();
        check("rd_done_once", done_o, 0);

        // Read timeout: req_o high exactly 4 cycles
        re = 1'b1; hs_if.rdata_i = 32'h0000_0000;
        tick();
        re = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_req_hi", hs_if.req_o, 1);
            check("tmo_no_err_yet", err_tmo_o, 0);
            if (i < 3) tick();
        end
        tick();
        check("tmo_req_end", hs_if.req_o, 0);
        check("tmo_done", done_o, 1);
        check("tmo_qs", qs, ERRV);
        check("tmo_err", err_tmo_o, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_err_clr", err_tmo_o, 0);

        // Collision in IDLE, then a dropped write during REQ
        re = 1'b1; we = 1'b1; wd = 32'h0000_1111;
        tick();
        re = 1'b0; we = 1'b1; wd = 32'h2222_2222;
        check("col_req_we", hs_if.req_we_o, 1);
        check("col_req_wd", hs_if.req_wd_o, 32'h0000_1111);
        check("col_ovf", err_ovf_o, 1);
        tick();
        we = 1'b0;
        check("ovf_req_wd_hold", hs_if.req_wd_o, 32'h0000_1111);
        check("ovf_busy", busy_o, 1);
        hs_if.ack_i = 1'b1; hs_if.rdata_i = 32'hCAFE_0000;
        tick();
        hs_if.ack_i = 1'b0;
        check("ovf_done", done_o, 1);
        check("ovf_wr_qs_keep", qs, ERRV);
        tick();
        check("ovf_no_second_req", hs_if.req_o, 0);
        check("ovf_sticky", err_ovf_o, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", err_ovf_o, 0);

        // Ack on the timeout cycle wins
        re = 1'b1; hs_if.rdata_i = 32'h0BAD_F00D;
        tick();
        re = 1'b0;
        tick(); tick(); tick();
        check("ackt_req_c4", hs_if.req_o, 1);
        hs_if.ack_i = 1'b1;
        tick();
        hs_if.ack_i = 1'b0;
        check("ackt_done", done_o, 1);
        check("ackt_qs", qs, 32'h0BAD_F00D);
        check("ackt_no_err", err_tmo_o, 0);

        // Timeout set and err_clr in the same cycle: set wins
        re = 1'b1;
        tick();
        re = 1'b0;
        tick(); tick(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("setclr_err", err_tmo_o, 1);
        check("setclr_qs", qs, ERRV);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("setclr_cleared", err_tmo_o, 0);

        // Reset in the 2nd REQ cycle, then a late ack
        we = 1'b1; wd = 32'h7777_0000;
        tick();
        we = 1'b0;
        tick();
        check("mrst_req_c2", hs_if.req_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_req", hs_if.req_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_qs", qs, RESVAL);
        check("mrst_req_wd", hs_if.req_wd_o, 0);
        hs_if.ack_i = 1'b1; hs_if.rdata_i = 32'h5555_5555;
        tick();
        hs_if.ack_i = 1'b0;
        check("late_ack_done", done_o, 0);
        check("late_ack_qs", qs, RESVAL);
        check("late_ack_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_abr_prim_subreg_ext_hs
